// File: rtl/puzzle_loader.sv
// Loads one Sudoku puzzle from a synchronous ROM into shadow registers, rotating the digits,
// then commits board and visibilities in a single cycle so a partial board is never visible.
module puzzle_loader #(
  parameter int unsigned PUZZLES_PER_LEVEL = 4,
  parameter int unsigned ROM_ADDR_W        = 12,
  parameter logic [7:0]  LFSR_SEED         = 8'hA5,
  parameter bit          ENABLE_REMAP      = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic                  i_difficulty,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [4:0]            i_rom_data,
  output logic [323:0]          o_board,
  output logic [80:0]           o_visibilities,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_bad_data
);

  localparam int unsigned SelW = (PUZZLES_PER_LEVEL > 1) ? $clog2(PUZZLES_PER_LEVEL) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCommit} state_e;

  state_e                  r_state, w_state_next;
  logic [7:0]              r_lfsr;
  logic [SelW-1:0]         r_sel;
  logic [3:0]              r_off;
  logic                    r_diff;
  logic [6:0]              r_cnt;
  logic                    r_wr_vld;
  logic [6:0]              r_wr_idx;
  logic [323:0]            r_shadow_board;
  logic [80:0]             r_shadow_vis;
  logic [323:0]            r_board;
  logic [80:0]             r_vis;
  logic                    r_bad;

  logic                    w_fb;
  logic [SelW-1:0]         w_sel;
  logic [3:0]              w_off;
  logic [ROM_ADDR_W-1:0]   w_puzzle;
  logic [ROM_ADDR_W-1:0]   w_addr;
  logic [3:0]              w_val;
  logic                    w_in_range;
  logic [4:0]              w_sum;
  logic [3:0]              w_wr_val;

  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_sel = (PUZZLES_PER_LEVEL > 1) ? r_lfsr[SelW-1:0] : '0;

  always_comb begin
    w_off = 4'd0;
    if (ENABLE_REMAP) begin
      w_off = (r_lfsr[7:4] >= 4'd9) ? (r_lfsr[7:4] - 4'd9) : r_lfsr[7:4];
    end
  end

  always_comb begin
    w_puzzle = ROM_ADDR_W'(r_diff) * ROM_ADDR_W'(PUZZLES_PER_LEVEL) + ROM_ADDR_W'(r_sel);
    w_addr   = w_puzzle * ROM_ADDR_W'(81) + ROM_ADDR_W'(r_cnt);
  end

  // Digits 1..9 rotate modulo 9; anything else passes through and flags bad data.
  always_comb begin
    w_val      = i_rom_data[3:0];
    w_in_range = (w_val != 4'd0) && (w_val <= 4'd9);
    w_sum      = {1'b0, w_val} + {1'b0, r_off};
    w_wr_val   = w_val;
    if (w_in_range) begin
      w_wr_val = (w_sum > 5'd9) ? 4'(w_sum - 5'd9) : w_sum[3:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (i_start) w_state_next = StLoad;
      StLoad:   if (r_cnt == 7'd80) w_state_next = StDrain;
      StDrain:  w_state_next = StCommit;
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    if (i_clear) w_state_next = StIdle;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_lfsr         <= LFSR_SEED;
      r_sel          <= '0;
      r_off          <= 4'd0;
      r_diff         <= 1'b0;
      r_cnt          <= 7'd0;
      r_wr_vld       <= 1'b0;
      r_wr_idx       <= 7'd0;
      r_shadow_board <= '0;
      r_shadow_vis   <= '0;
      r_board        <= '0;
      r_vis          <= '0;
      r_bad          <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lfsr  <= {r_lfsr[6:0], w_fb};
      if (i_clear) begin
        r_cnt    <= 7'd0;
        r_wr_vld <= 1'b0;
        r_board  <= '0;
        r_vis    <= '0;
        r_bad    <= 1'b0;
      end else begin
        // The ROM answers one cycle later, so the write trails the address by one cycle.
        r_wr_vld <= (r_state == StLoad);
        r_wr_idx <= r_cnt;
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_sel          <= w_sel;
              r_off          <= w_off;
              r_diff         <= i_difficulty;
              r_cnt          <= 7'd0;
              r_shadow_board <= '0;
              r_shadow_vis   <= '0;
              r_bad          <= 1'b0;
            end
          end
          StLoad:   r_cnt <= r_cnt + 7'd1;
          StCommit: begin
            r_board <= r_shadow_board;
            r_vis   <= r_shadow_vis;
          end
          default: ;
        endcase
        if (r_wr_vld) begin
          r_shadow_board[{r_wr_idx, 2'b00} +: 4] <= w_wr_val;
          r_shadow_vis[r_wr_idx]                 <= i_rom_data[4];
          if (!w_in_range) r_bad <= 1'b1;
        end
      end
    end
  end

  assign o_rom_addr     = (r_state == StLoad) ? w_addr : '0;
  assign o_board        = r_board;
  assign o_visibilities = r_vis;
  assign o_busy         = (r_state != StIdle);
  assign o_done         = (r_state == StCommit);
  assign o_bad_data     = r_bad;

endmodule
